// File: rtl/glb_stream_arbiter.sv
// glb_stream_arbiter
// Block-granular round-robin arbiter sharing one GLB-bound ready/valid channel
// among NUM_REQ length-prefixed streams. A block is a header word carrying the
// data word count N in its low LEN_WIDTH bits, followed by N data words. The
// arbiter owns one requester from header to last data word, so blocks never
// interleave on the shared channel.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear, same effect as reset, highest priority
//   in_data      requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid     per-requester valid
//   in_ready     per-requester ready (only the owner may see ready)
//   out_data     shared channel word (combinational from the owner)
//   out_valid    shared channel valid
//   out_ready    shared channel ready
//   grant        one-hot current owner, 0 when idle
//   busy         high while a block is in flight
//   blocks_done  completed-block count since reset/flush (wraps at 2^16)
module glb_stream_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 17,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [15:0]                   blocks_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [15:0]          blocks_done_q, blocks_done_d;

    logic [DATA_WIDTH-1:0] granted_word_s;
    logic                  handshake_s;
    logic                  pick_found_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  found_hi_s;
    logic [IDX_W-1:0]      idx_hi_s;
    logic [IDX_W-1:0]      idx_lo_s;

    // Round-robin pick: lowest valid index at or above rr_ptr, else wrap to lowest valid.
    // Descending scans leave the lowest matching index in the result.
    always_comb begin
        found_hi_s = 1'b0;
        idx_hi_s   = '0;
        idx_lo_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (in_valid[i] && (IDX_W'(i) >= rr_ptr_q)) begin
                found_hi_s = 1'b1;
                idx_hi_s   = IDX_W'(i);
            end else begin
                found_hi_s = found_hi_s;
            end
            if (in_valid[i]) begin
                idx_lo_s = IDX_W'(i);
            end else begin
                idx_lo_s = idx_lo_s;
            end
        end
        pick_found_s = |in_valid;
        if (found_hi_s) begin
            pick_idx_s = idx_hi_s;
        end else begin
            pick_idx_s = idx_lo_s;
        end
    end

    // Zero-latency pass-through from the owner; everything is quiet in IDLE.
    always_comb begin
        granted_word_s = '0;
        out_data       = '0;
        out_valid      = 1'b0;
        in_ready       = '0;
        grant          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                granted_word_s = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                granted_word_s = granted_word_s;
            end
        end
        if (state_q != ST_IDLE) begin
            out_data = granted_word_s;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    out_valid   = in_valid[i];
                    in_ready[i] = out_ready;
                    grant[i]    = 1'b1;
                end else begin
                    in_ready[i] = 1'b0;
                end
            end
        end else begin
            out_data = '0;
        end
    end

    assign handshake_s = out_valid & out_ready;
    assign busy        = (state_q != ST_IDLE);
    assign blocks_done = blocks_done_q;

    // Next-state: arbitrate in IDLE, count the block down, retire on the last word.
    always_comb begin
        logic complete_v;
        complete_v    = 1'b0;
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        remaining_d   = remaining_q;
        blocks_done_d = blocks_done_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_HEADER;
                    owner_d = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (handshake_s) begin
                    if (granted_word_s[LEN_WIDTH-1:0] == '0) begin
                        complete_v = 1'b1;
                    end else begin
                        remaining_d = granted_word_s[LEN_WIDTH-1:0];
                        state_d     = ST_BODY;
                    end
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_BODY: begin
                if (handshake_s) begin
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        complete_v = 1'b1;
                    end else begin
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_BODY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Completion hands top priority to the next requester after the owner.
        if (complete_v) begin
            state_d       = ST_IDLE;
            remaining_d   = '0;
            blocks_done_d = blocks_done_q + 16'd1;
            if (owner_q == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = owner_q + IDX_W'(1);
            end
        end else begin
            blocks_done_d = blocks_done_d;
        end
    end

    // State registers; flush abandons any in-flight block ahead of a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            remaining_q   <= '0;
            blocks_done_q <= 16'd0;
        end else if (flush) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            remaining_q   <= '0;
            blocks_done_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            remaining_q   <= remaining_d;
            blocks_done_q <= blocks_done_d;
        end
    end

endmodule

// File: tb/tb_glb_stream_arbiter.sv
// Randomized scoreboard bench for glb_stream_arbiter. Per-requester drivers
// present length-prefixed blocks with random valid gaps; a reference model
// working in block/word terms predicts owner, count and forwarded words; a
// separate monitor compares the DUT against it every cycle.
module tb_glb_stream_arbiter;

    localparam int NR = 3;
    localparam int DW = 17;
    localparam int LW = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [NR*DW-1:0]   in_data;
    logic [NR-1:0]      in_valid;
    logic [NR-1:0]      in_ready;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic [NR-1:0]      grant;
    logic               busy;
    logic [15:0]        blocks_done;

    glb_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .busy(busy), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Stimulus sources and expected-word scoreboard
    logic [DW-1:0] src_q [NR][$];
    logic [DW-1:0] exp_q [$];

    // Reference model: owner (-1 = none), header-expected flag, words left, rr start, count
    int m_owner = -1;
    bit m_hdr   = 1'b0;
    int m_rem   = 0;
    int m_rr    = 0;
    int m_done  = 0;

    // Expectations published for the monitor each cycle
    logic [NR-1:0] chk_grant;
    logic [NR-1:0] chk_ready;
    logic          chk_valid;
    logic          chk_flush;
    logic [15:0]   chk_done;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hdr   = 1'b0;
        m_rem   = 0;
        m_rr    = 0;
        m_done  = 0;
        exp_q.delete();
        for (int i = 0; i < NR; i++) src_q[i].delete();
    endtask

    task automatic add_block(input int r);
        int len;
        logic [DW-1:0] h;
        len = ($urandom % 8 == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
        h = DW'($urandom);
        h[LW-1:0] = LW'(len);
        src_q[r].push_back(h);
        for (int k = 0; k < len; k++) src_q[r].push_back(DW'($urandom));
    endtask

    task automatic model_complete();
        m_done  = (m_done + 1) % 65536;
        m_rr    = (m_owner + 1) % NR;
        m_owner = -1;
    endtask

    // One posedge worth of specification behaviour on the currently driven inputs
    task automatic model_step();
        logic [DW-1:0] w;
        bit was_idle;
        was_idle = (m_owner < 0);
        if (!was_idle && in_valid[m_owner] && out_ready) begin
            w = in_data[m_owner*DW +: DW];
            exp_q.push_back(w);
            if (m_hdr) begin
                m_hdr = 1'b0;
                if (w[LW-1:0] == 0) model_complete();
                else m_rem = int'(w[LW-1:0]);
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) model_complete();
            end
        end
        if (was_idle) begin
            for (int k = 0; k < NR; k++) begin
                if (m_owner < 0 && in_valid[(m_rr + k) % NR]) begin
                    m_owner = (m_rr + k) % NR;
                    m_hdr   = 1'b1;
                end
            end
        end
    endtask

    // Monitor: compares control outputs every cycle and pops the scoreboard on transfers
    always begin
        @(negedge clk);
        #2;
        if (mon_en && rst_n) begin
            check("grant", 32'(grant), 32'(chk_grant));
            check("busy", 32'(busy), 32'(chk_grant != '0));
            check("in_ready", 32'(in_ready), 32'(chk_ready));
            check("out_valid", 32'(out_valid), 32'(chk_valid));
            check("blocks_done", 32'(blocks_done), 32'(chk_done));
            if (!chk_flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [NR-1:0] hs;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_blocks_done", 32'(blocks_done), 32'd0);
        in_valid = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush = (cyc % 400 == 250);
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() == 0 && $urandom % 3 == 0) add_block(i);
                if (src_q[i].size() != 0 && $urandom % 4 != 0) begin
                    in_valid[i]            = 1'b1;
                    in_data[i*DW +: DW]    = src_q[i][0];
                end else begin
                    in_valid[i]            = 1'b0;
                    in_data[i*DW +: DW]    = DW'($urandom);
                end
            end
            out_ready = (cyc < 800) ? 1'b1 : ($urandom % 4 != 0);
            #1;
            chk_grant = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
            chk_ready = out_ready ? chk_grant : '0;
            chk_valid = (m_owner >= 0) ? in_valid[m_owner] : 1'b0;
            chk_done  = 16'(m_done);
            chk_flush = flush;
            hs = in_valid & in_ready;
            if (flush) begin
                model_reset();
                hs = '0;
            end else begin
                model_step();
            end
            if (cyc == 1700 || cyc == 2600) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_out_valid", 32'(out_valid), 32'd0);
                check("async_in_ready", 32'(in_ready), 32'd0);
                check("async_grant", 32'(grant), 32'd0);
                check("async_busy", 32'(busy), 32'd0);
                model_reset();
                hs = '0;
            end
            @(posedge clk);
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
        end
        mon_en = 1'b0;
        #3;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/glb_stream_arbiter.md
# glb_stream_arbiter

Block-granular round-robin arbiter that shares one GLB-bound ready/valid stream channel among NUM_REQ memory-core output streams. Each requester emits length-prefixed blocks: a header word holding the word count N, then N data words. The arbiter locks onto one requester for a whole block, header through last data word, so blocks never interleave on the shared channel. It sits between the core output ports and the single GLB write/read channel.

## Interface
- NUM_REQ, 2: number of requesting streams (2..8).
- DATA_WIDTH, 17: stream word width.
- LEN_WIDTH, 16: header bits interpreted as block length (data[LEN_WIDTH-1:0]).
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous clear; same effect as reset, applied on the next posedge.
- in_data  input  NUM_REQ*DATA_WIDTH  requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_REQ  per-requester valid.
- in_ready  output  NUM_REQ  per-requester ready.
- out_data  output  DATA_WIDTH  shared channel word.
- out_valid  output  1  shared channel valid.
- out_ready  input  1  shared channel ready.
- grant  output  NUM_REQ  one-hot current owner; 0 when idle.
- busy  output  1  high while a block is in flight (HEADER or BODY).
- blocks_done  output  16  count of completed blocks since reset/flush.

## Operation
- FSM states: IDLE, HEADER, BODY.
- IDLE: if any in_valid is high, pick the first valid requester searching from rr_ptr upward with wrap-around. Register grant, go to HEADER. If none is valid, stay.
- HEADER: combinational pass-through: out_data = in_data[g], out_valid = in_valid[g], in_ready[g] = out_ready. On handshake (out_valid & out_ready), capture len = header[LEN_WIDTH-1:0].
  - len == 0: block complete, go to IDLE.
  - len != 0: remaining = len, go to BODY.
- BODY: same pass-through. Each handshake decrements remaining. A handshake with remaining == 1 completes the block and goes to IDLE.
- Block completion does three things: blocks_done += 1 (wraps mod 2^16), rr_ptr = g+1 mod NUM_REQ, grant cleared.
- Non-granted in_ready are always 0. All in_ready are 0 in IDLE.
- Header bits above LEN_WIDTH are forwarded unchanged and ignored for counting.
- Reset and flush both force IDLE, rr_ptr = 0, grant = 0, remaining = 0, blocks_done = 0. An in-flight block is abandoned: no further words are forwarded and the count is not incremented. Flush has priority over any same-cycle handshake.

## Timing
- Reset values: out_valid 0, out_data 0, in_ready 0, grant 0, busy 0, blocks_done 0.
- Data path latency is 0 cycles (combinational from granted input to output). ready/valid semantics: transfer iff valid & ready at posedge.
- Arbitration costs exactly 1 cycle. A requester valid in IDLE at edge k sees grant and in_ready from cycle k+1. A block of N words therefore occupies at least N+2 cycles including the IDLE gap. There is no back-to-back block without an IDLE cycle.
- out_valid is 0 in IDLE even if inputs are valid.
- Requester valid may drop mid-block. The arbiter holds grant and waits; there is no timeout.
- busy = (state != IDLE), registered with state.
- Round-robin: after requester i completes, requester i+1 has highest priority. With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Max block: len = 2^LEN_WIDTH-1. remaining is LEN_WIDTH bits wide and never underflows.
- Async reset assertion mid-transfer immediately drops out_valid and in_ready.

## Test plan
- Single block: req0 sends header 3, data A,B,C, out_ready=1. Required: out shows 3,A,B,C on consecutive cycles starting 1 cycle after valid. grant=01 throughout. blocks_done 0->1. Returns to IDLE.
- Contention: req0 and req1 both valid from reset, each sending header 2 and two words. Required: req0 block first, 1 idle cycle, then req1 block. grant sequence 01,00,10. blocks_done=2. No interleaving.
- Zero length: req1 sends header 0. Required: a single header transfer, blocks_done increments, rr_ptr moves to 0, and the next grant goes to req0 when both are valid.
- Backpressure: header 4, out_ready toggling 1,0,0,1,... Required: in_ready[g] tracks out_ready each cycle, exactly 5 transfers, no duplicated or dropped word.
- Flush mid-block: header 5, assert flush after 2 data words. Required: next cycle state IDLE, grant 0, blocks_done 0, in_ready 0. A subsequent block from req1 is granted first (rr_ptr=0, req0 idle) and completes normally.
- Async reset mid-block: drop rst_n between edges. Required: out_valid and in_ready go to 0 immediately without waiting for a clock edge. After release, behaviour is identical to a fresh power-up.
